// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the data memory arbiter.
//   arb_state_t   : arbiter FSM states
//   WORD_BYTES    : bytes per memory word (per-beat address stride)
//   MAX_BURST_DEF : default maximum beats per burst
//   clip_len()    : maps a requested length to the effective beat count
package data_mem_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_BURST
  } arb_state_t;

  localparam int unsigned WORD_BYTES    = 4;
  localparam int unsigned MAX_BURST_DEF = 4;

  // A zero length still moves one word; oversize requests are clipped.
  function automatic logic [2:0] clip_len(input logic [2:0] len,
                                          input logic [2:0] max_len);
    if (len == 3'd0) return 3'd1;
    if (len > max_len) return max_len;
    return len;
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter.
//   clk, reset : clock, synchronous active-high reset
//   req        : request lines of both requesters
//   take       : the current winner is being granted (updates last_grant)
//   winner     : index of the requester that wins this cycle
//   any_valid  : at least one request is present
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       take,
  output logic       winner,
  output logic       any_valid
);

  // Resets to 1 so requester 0 wins the first tie.
  logic last_grant;

  always_comb begin
    any_valid = |req;
    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last_grant;
      default: winner = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (take && any_valid) begin
      last_grant <= winner;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the single-port data RAM between the core load/store unit (port 0)
// and the image/program loader (port 1). Round-robin arbitration, grant held
// for a whole burst of up to MAX_BURST word beats, one beat per cycle.
//   clk, reset : clock, synchronous active-high reset
//   rq_valid   : per-requester request, held until its final rq_ready
//   rq_write   : 1 = write burst, 0 = read burst
//   rq_addr    : burst base byte address (low two bits ignored)
//   rq_len     : requested beats (0 -> 1, >MAX_BURST -> MAX_BURST)
//   rq_wdata   : write data for the current beat
//   rq_ready   : beat accepted pulse for the granted requester
//   rs_valid   : read data valid, one cycle after each read beat
//   rs_rdata   : shared read data bus, qualified by rs_valid
//   mem_addr   : RAM byte address
//   mem_we     : RAM write enable
//   mem_wdata  : RAM write data
//   mem_rdata  : RAM read data (1-cycle synchronous read)
//   grant_id   : requester currently owning the RAM
//   busy       : a burst is in progress
module data_mem_arbiter
  import data_mem_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             rq_valid,
  input  logic [1:0]             rq_write,
  input  logic [1:0][ADDR_W-1:0] rq_addr,
  input  logic [1:0][2:0]        rq_len,
  input  logic [1:0][DATA_W-1:0] rq_wdata,
  output logic [1:0]             rq_ready,
  output logic [1:0]             rs_valid,
  output logic [DATA_W-1:0]      rs_rdata,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic                   mem_we,
  output logic [DATA_W-1:0]      mem_wdata,
  input  logic [DATA_W-1:0]      mem_rdata,
  output logic                   grant_id,
  output logic                   busy
);

  arb_state_t        state, state_n;
  logic [ADDR_W-1:0] base;
  logic              wr;
  logic [2:0]        len;
  logic [2:0]        beat;
  logic [1:0]        rs_valid_q;

  logic              winner;
  logic              any_valid;
  logic              take;
  logic              fire;
  logic              last_beat;
  logic [ADDR_W-1:0] beat_addr;
  logic [ADDR_W-1:0] win_addr;

  rr_arbiter_2 u_rr (
    .clk       (clk),
    .reset     (reset),
    .req       (rq_valid),
    .take      (take),
    .winner    (winner),
    .any_valid (any_valid)
  );

  assign win_addr  = rq_addr[winner];
  assign beat_addr = base + (ADDR_W'(beat) * ADDR_W'(WORD_BYTES));
  assign last_beat = (beat == (len - 3'd1));

  always_comb begin
    state_n   = state;
    take      = 1'b0;
    fire      = 1'b0;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    rq_ready  = '0;
    case (state)
      ARB_IDLE: begin
        if (any_valid) begin
          take    = 1'b1;
          state_n = ARB_BURST;
        end
      end
      ARB_BURST: begin
        if (!rq_valid[grant_id]) begin
          // Requester withdrew: abort without issuing a beat.
          state_n = ARB_IDLE;
        end else begin
          // Reset cycle must not commit a write or accept a beat.
          fire               = ~reset;
          mem_addr           = beat_addr;
          mem_we             = wr & ~reset;
          mem_wdata          = wr ? rq_wdata[grant_id] : '0;
          rq_ready[grant_id] = ~reset;
          if (last_beat) state_n = ARB_IDLE;
        end
      end
      default: state_n = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ARB_IDLE;
      grant_id   <= 1'b0;
      base       <= '0;
      wr         <= 1'b0;
      len        <= 3'd1;
      beat       <= '0;
      rs_valid_q <= '0;
    end else begin
      state      <= state_n;
      rs_valid_q <= (fire && !wr) ? {grant_id, ~grant_id} : 2'b00;
      if (take) begin
        grant_id <= winner;
        base     <= {win_addr[ADDR_W-1:2], 2'b00};
        wr       <= rq_write[winner];
        len      <= clip_len(rq_len[winner], 3'(MAX_BURST));
        beat     <= '0;
      end else if (fire) begin
        beat <= beat + 3'd1;
      end
    end
  end

  // The RAM's own read register supplies the data cycle; only the valid
  // tag needs registering here.
  assign rs_valid = rs_valid_q;
  assign rs_rdata = mem_rdata;
  assign busy     = (state == ARB_BURST);

endmodule

// File: tb/tb_data_mem_arbiter.sv
module tb_data_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [1:0]             rq_valid, rq_write;
  logic [1:0][ADDR_W-1:0] rq_addr;
  logic [1:0][2:0]        rq_len;
  logic [1:0][DATA_W-1:0] rq_wdata;
  logic [1:0]             rq_ready, rs_valid;
  logic [DATA_W-1:0]      rs_rdata, mem_wdata, mem_rdata;
  logic [ADDR_W-1:0]      mem_addr;
  logic                   mem_we, grant_id, busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  data_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset), .rq_valid(rq_valid), .rq_write(rq_write),
    .rq_addr(rq_addr), .rq_len(rq_len), .rq_wdata(rq_wdata),
    .rq_ready(rq_ready), .rs_valid(rs_valid), .rs_rdata(rs_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .grant_id(grant_id), .busy(busy)
  );

  // RAM model: 1024 words, synchronous read, plus a preload port.
  logic [31:0] mem [0:1023];
  logic        pre_we = 1'b0;
  logic [9:0]  pre_idx = '0;
  logic [31:0] pre_data = '0;

  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_data;
    else if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[11:2]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rq_valid = '0; rq_write = '0; rq_addr = '0; rq_len = '0; rq_wdata = '0;
  endtask

  task automatic set_req(input int p, input logic w, input logic [31:0] a,
                         input logic [2:0] l, input logic [31:0] d);
    rq_valid[p] = 1'b1; rq_write[p] = w; rq_addr[p] = a;
    rq_len[p] = l; rq_wdata[p] = d;
  endtask

  task automatic preload(input logic [9:0] idx, input logic [31:0] d);
    pre_we = 1'b1; pre_idx = idx; pre_data = d;
    tick();
    pre_we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0h expected 0", busy); end
    tests++; if (rq_ready !== 2'b00) begin fails++; $display("FAIL reset_rq_ready: got %b expected 00", rq_ready); end
    tests++; if (rs_valid !== 2'b00) begin fails++; $display("FAIL reset_rs_valid: got %b expected 00", rs_valid); end
    tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL reset_mem_we: got %0h expected 0", mem_we); end
    tests++; if (mem_addr !== 32'h0) begin fails++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
    tests++; if (mem_wdata !== 32'h0) begin fails++; $display("FAIL reset_mem_wdata: got %h expected 0", mem_wdata); end
    tests++; if (grant_id !== 1'b0) begin fails++; $display("FAIL reset_grant_id: got %0h expected 0", grant_id); end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_scalar_read();
    preload(10'h040, 32'hCAFEF00D);
    set_req(0, 1'b0, 32'h100, 3'd1, 32'h0);
    @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL sread_req_busy: got %0h expected 0", busy); end
    tick();
    @(negedge clk);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL sread_busy: got %0h expected 1", busy); end
    tests++; if (grant_id !== 1'b0) begin fails++; $display("FAIL sread_grant: got %0h expected 0", grant_id); end
    tests++; if (mem_addr !== 32'h100) begin fails++; $display("FAIL sread_addr: got %h expected 00000100", mem_addr); end
    tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL sread_we: got %0h expected 0", mem_we); end
    tests++; if (rq_ready !== 2'b01) begin fails++; $display("FAIL sread_ready: got %b expected 01", rq_ready); end
    tick();
    rq_valid = 2'b00;
    @(negedge clk);
    tests++; if (rs_valid !== 2'b01) begin fails++; $display("FAIL sread_rs_valid: got %b expected 01", rs_valid); end
    tests++; if (rs_rdata !== 32'hCAFEF00D) begin fails++; $display("FAIL sread_rdata: got %h expected cafef00d", rs_rdata); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL sread_idle: got %0h expected 0", busy); end
    tick();
  endtask

  task automatic test_vector_write();
    set_req(0, 1'b1, 32'h200, 3'd4, 32'd1);
    tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++; if (mem_addr !== 32'h200 + 32'(4 * i)) begin fails++; $display("FAIL vwrite_addr%0d: got %h expected %h", i, mem_addr, 32'h200 + 32'(4 * i)); end
      tests++; if (mem_we !== 1'b1) begin fails++; $display("FAIL vwrite_we%0d: got %0h expected 1", i, mem_we); end
      tests++; if (mem_wdata !== 32'(i + 1)) begin fails++; $display("FAIL vwrite_wdata%0d: got %h expected %h", i, mem_wdata, 32'(i + 1)); end
      tests++; if (rq_ready !== 2'b01) begin fails++; $display("FAIL vwrite_ready%0d: got %b expected 01", i, rq_ready); end
      tick();
      if (i < 3) rq_wdata[0] = 32'(i + 2);
      else rq_valid = 2'b00;
    end
    @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL vwrite_idle: got %0h expected 0", busy); end
    tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL vwrite_we_after: got %0h expected 0", mem_we); end
    tick();
    for (int i = 0; i < 4; i++) begin
      tests++; if (mem[10'h080 + 10'(i)] !== 32'(i + 1)) begin fails++; $display("FAIL vwrite_stored%0d: got %h expected %h", i, mem[10'h080 + 10'(i)], 32'(i + 1)); end
    end
  endtask

  task automatic test_arbitration();
    reset = 1'b1;
    idle_inputs();
    tick();
    reset = 1'b0;
    set_req(0, 1'b0, 32'h100, 3'd4, 32'h0);
    set_req(1, 1'b1, 32'h300, 3'd1, 32'h55);
    tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++; if (grant_id !== 1'b0) begin fails++; $display("FAIL arb_first_grant%0d: got %0h expected 0", i, grant_id); end
      tests++; if (rq_ready !== 2'b01) begin fails++; $display("FAIL arb_first_ready%0d: got %b expected 01", i, rq_ready); end
      tick();
    end
    // Port 0 immediately re-requests: a tie in the idle cycle.
    set_req(0, 1'b0, 32'h100, 3'd1, 32'h0);
    @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL arb_gap_busy: got %0h expected 0", busy); end
    tests++; if (rq_ready !== 2'b00) begin fails++; $display("FAIL arb_gap_ready: got %b expected 00", rq_ready); end
    tests++; if (rs_valid !== 2'b01) begin fails++; $display("FAIL arb_last_rs_valid: got %b expected 01", rs_valid); end
    tick();
    @(negedge clk);
    tests++; if (grant_id !== 1'b1) begin fails++; $display("FAIL arb_second_grant: got %0h expected 1", grant_id); end
    tests++; if (rq_ready !== 2'b10) begin fails++; $display("FAIL arb_second_ready: got %b expected 10", rq_ready); end
    tests++; if (mem_we !== 1'b1) begin fails++; $display("FAIL arb_second_we: got %0h expected 1", mem_we); end
    tests++; if (mem_addr !== 32'h300) begin fails++; $display("FAIL arb_second_addr: got %h expected 00000300", mem_addr); end
    tests++; if (mem_wdata !== 32'h55) begin fails++; $display("FAIL arb_second_wdata: got %h expected 00000055", mem_wdata); end
    tick();
    rq_valid[1] = 1'b0;
    @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL arb_gap2_busy: got %0h expected 0", busy); end
    tick();
    @(negedge clk);
    tests++; if (grant_id !== 1'b0) begin fails++; $display("FAIL arb_third_grant: got %0h expected 0", grant_id); end
    tests++; if (rq_ready !== 2'b01) begin fails++; $display("FAIL arb_third_ready: got %b expected 01", rq_ready); end
    tick();
    rq_valid = 2'b00;
    tick();
  endtask

  task automatic test_len_clip();
    logic [2:0] lens [2];
    int         exp_beats [2];
    int         cnt;
    bit         seen, done;
    lens[0] = 3'd0; exp_beats[0] = 1;
    lens[1] = 3'd7; exp_beats[1] = 4;
    for (int k = 0; k < 2; k++) begin
      set_req(0, 1'b0, 32'h100, lens[k], 32'h0);
      cnt = 0; seen = 0; done = 0;
      for (int c = 0; c < 12 && !done; c++) begin
        @(negedge clk);
        if (rq_ready[0]) cnt++;
        if (busy) seen = 1;
        else if (seen) begin
          rq_valid = 2'b00;
          done = 1;
        end
        tick();
      end
      rq_valid = 2'b00;
      tests++; if (!done) begin fails++; $display("FAIL len%0d_timeout: burst did not end within 12 cycles", lens[k]); end
      tests++; if (cnt !== exp_beats[k]) begin fails++; $display("FAIL len%0d_beats: got %0d expected %0d", lens[k], cnt, exp_beats[k]); end
      tick();
    end
  endtask

  task automatic test_abort();
    preload(10'h0D2, 32'hDEADBEEF);
    set_req(1, 1'b1, 32'h340, 3'd4, 32'hA0);
    tick();
    @(negedge clk);
    tests++; if (mem_addr !== 32'h340 || mem_we !== 1'b1) begin fails++; $display("FAIL abort_beat0: got addr %h we %0h expected 00000340 1", mem_addr, mem_we); end
    tests++; if (rq_ready !== 2'b10) begin fails++; $display("FAIL abort_ready0: got %b expected 10", rq_ready); end
    tick();
    rq_wdata[1] = 32'hA1;
    @(negedge clk);
    tests++; if (mem_addr !== 32'h344 || mem_we !== 1'b1) begin fails++; $display("FAIL abort_beat1: got addr %h we %0h expected 00000344 1", mem_addr, mem_we); end
    tick();
    rq_valid = 2'b00;
    @(negedge clk);
    tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL abort_no_we: got %0h expected 0", mem_we); end
    tests++; if (rq_ready !== 2'b00) begin fails++; $display("FAIL abort_no_ready: got %b expected 00", rq_ready); end
    tick();
    @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_idle: got %0h expected 0", busy); end
    tick();
    tests++; if (mem[10'h0D0] !== 32'hA0) begin fails++; $display("FAIL abort_word0: got %h expected 000000a0", mem[10'h0D0]); end
    tests++; if (mem[10'h0D1] !== 32'hA1) begin fails++; $display("FAIL abort_word1: got %h expected 000000a1", mem[10'h0D1]); end
    tests++; if (mem[10'h0D2] !== 32'hDEADBEEF) begin fails++; $display("FAIL abort_word2: got %h expected deadbeef", mem[10'h0D2]); end
  endtask

  task automatic test_wrap();
    set_req(0, 1'b1, 32'hFFFF_FFFE, 3'd2, 32'h11);
    tick();
    @(negedge clk);
    tests++; if (mem_addr !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_addr0: got %h expected fffffffc", mem_addr); end
    tick();
    rq_wdata[0] = 32'h22;
    @(negedge clk);
    tests++; if (mem_addr !== 32'h0) begin fails++; $display("FAIL wrap_addr1: got %h expected 00000000", mem_addr); end
    tests++; if (mem_wdata !== 32'h22) begin fails++; $display("FAIL wrap_wdata1: got %h expected 00000022", mem_wdata); end
    tick();
    rq_valid = 2'b00;
    tick();
  endtask

  task automatic test_reset_mid_burst();
    set_req(0, 1'b0, 32'h100, 3'd4, 32'h0);
    tick();
    tick();
    @(negedge clk);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rmid_busy_before: got %0h expected 1", busy); end
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_req(0, 1'b0, 32'h100, 3'd1, 32'h0);
    set_req(1, 1'b1, 32'h300, 3'd1, 32'h77);
    @(negedge clk);
    tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL rmid_we: got %0h expected 0", mem_we); end
    tests++; if (rs_valid !== 2'b00) begin fails++; $display("FAIL rmid_rs_valid: got %b expected 00", rs_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rmid_busy: got %0h expected 0", busy); end
    tick();
    @(negedge clk);
    tests++; if (grant_id !== 1'b0) begin fails++; $display("FAIL rmid_tie_grant: got %0h expected 0", grant_id); end
    tests++; if (rq_ready !== 2'b01) begin fails++; $display("FAIL rmid_tie_ready: got %b expected 01", rq_ready); end
    tick();
    rq_valid = 2'b00;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_scalar_read();
    test_vector_write();
    test_arbitration();
    test_len_clip();
    test_abort();
    test_wrap();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
